branch_unit_bht: RTL and testbench
==================================

Name: branch_unit_bht

Overview:
Parametrised successor to the single-cycle zero-flag branch decision. Resolves all six RV32I conditional branches directly from the operands, with signed and unsigned compares. Also holds a 2-bit saturating branch history table (BHT) that supplies a taken/not-taken prediction at fetch. Sits between IF (prediction lookup) and EX (resolution, BHT training, registered redirect/flush to the PC mux and pipeline registers).

Parameters:
XLEN, 32, operand/PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >= 2
CTR_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
if_pc  input  XLEN  fetch PC for lookup
if_pred_taken  output  1  prediction for if_pc, combinational, from counter MSB
ex_valid  input  1  EX stage holds a valid instruction
ex_branch  input  1  EX instruction is a conditional branch
ex_func3  input  3  branch funct3
ex_rs1  input  XLEN  operand 1
ex_rs2  input  XLEN  operand 2
ex_pc  input  XLEN  PC of the EX instruction
ex_imm  input  XLEN  sign-extended B-immediate
ex_pred_taken  input  1  prediction carried down the pipe with this instruction
pc_sel  output  1  registered; 1 = PC mux takes redirect_pc
redirect_pc  output  XLEN  registered corrected next PC
flush  output  1  registered; squash IF/ID and ID/EX
br_illegal  output  1  registered one-cycle pulse; branch with reserved func3

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]. The same slice is used for lookup (if_pc) and update (ex_pc).
- Resolution is internal and combinational:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010/011 are reserved: actual_taken = 0, no BHT update, br_illegal = 1 next cycle.
- resolve = ex_valid & ex_branch & ~flush. While flush is high, the squashed EX content is ignored.
- mispredict = resolve & legal & (actual_taken != ex_pred_taken).
- Latency: outputs are registered, 1 cycle after the EX cycle.
  - On mispredict: pc_sel = 1 and flush = 1 for exactly one cycle.
  - redirect_pc = ex_pc + ex_imm if actual taken, else ex_pc + 4. Addition is modulo 2^XLEN; wrap-around is silent.
  - Otherwise pc_sel = 0, flush = 0, and redirect_pc holds its last value.
- BHT update at the clk edge when resolve & legal:
  - Taken: counter increments, saturating at 11.
  - Not-taken: counter decrements, saturating at 00.
- Same-cycle lookup and update of the same index: if_pred_taken reflects the pre-update value. There is no bypass.
- Back-to-back mispredicts are impossible, because flush masks the following cycle. The bench may still drive them; the second is ignored.
- Reset (asynchronous assert, synchronous-safe deassert):
  - pc_sel = 0, flush = 0, br_illegal = 0, redirect_pc = 0.
  - All counters = CTR_INIT.
  - Reset mid-operation discards any pending redirect.
- Counters are flops (not RAM) so the reset clears all of them in one step.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every resolve & legal.
  - stat_mispredicts increments on every mispredict.
  - Both are free-running, wrap at 2^32, and reset to 0.
- When undefined, neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset with reset_n = 0 mid-cycle -> all outputs 0 immediately; if_pred_taken = 0 for any if_pc (CTR_INIT = 01).
- BEQ, rs1 = rs2 = 5, ex_pc = 0x100, imm = 0x20, pred = 0 -> next cycle pc_sel = 1, flush = 1, redirect_pc = 0x120; the cycle after, pc_sel = 0.
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1 -> taken (signed). BLTU with the same operands -> not taken; with pred = 1 -> redirect_pc = ex_pc + 4.
- Train the same ex_pc taken 3 times -> counter saturates at 11. Two not-taken resolutions -> 01, and if_pred_taken = 0.
- func3 = 010 with ex_branch = 1 -> br_illegal pulses 1 cycle, no redirect, BHT entry unchanged.
- Mispredict followed by a valid branch in the flush cycle -> second branch ignored: no update, no second redirect. Stats (if BRANCH_STATS_EN) branches = 1, mispredicts = 1.

Source files
------------

// File: rtl/branch_unit_bht.sv
// Branch resolution for all six RV32I conditional branches plus a 2-bit saturating BHT.
// Optional performance counters are enabled by defining BRANCH_STATS_EN.
module branch_unit_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  output logic            pc_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
`ifdef BRANCH_STATS_EN
  output logic            br_illegal,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`else
  output logic            br_illegal
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ctr_vec [BHT_ENTRIES];
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_upd;

  logic             legal;
  logic             actual_taken;
  logic             resolve;
  logic             bht_update;
  logic             mispredict;
  logic [XLEN-1:0]  target_pc;

  logic             pc_sel_reg;
  logic             flush_reg;
  logic             br_illegal_reg;
  logic [XLEN-1:0]  redirect_pc_reg;
  logic [XLEN-1:0]  redirect_pc_next;

  // The low two PC bits and everything above the index are not needed for lookup.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign if_pred_taken = ctr_vec[if_idx][1];

  // funct3 010/011 are the only reserved encodings.
  assign legal = (ex_func3[2:1] != 2'b01);

  always_comb begin
    actual_taken = 1'b0;
    case (ex_func3)
      3'b000:  actual_taken = (ex_rs1 == ex_rs2);
      3'b001:  actual_taken = (ex_rs1 != ex_rs2);
      3'b100:  actual_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  actual_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  actual_taken = (ex_rs1 <  ex_rs2);
      3'b111:  actual_taken = (ex_rs1 >= ex_rs2);
      default: actual_taken = 1'b0;
    endcase
  end

  // The instruction in EX during a flush cycle is already squashed.
  assign resolve    = ex_valid & ex_branch & ~flush_reg;
  assign bht_update = resolve & legal;
  assign mispredict = bht_update & (actual_taken != ex_pred_taken);
  assign target_pc  = actual_taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

  assign ctr_cur = ctr_vec[ex_idx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (actual_taken) begin
      if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_ctr
      logic [1:0] ctr_reg;
      logic       hit;

      assign hit = bht_update && (ex_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ctr_reg <= CTR_INIT;
        end else if (hit) begin
          ctr_reg <= ctr_upd;
        end
      end

      assign ctr_vec[gi] = ctr_reg;
    end
  endgenerate

  assign redirect_pc_next = mispredict ? target_pc : redirect_pc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_sel_reg      <= 1'b0;
      flush_reg       <= 1'b0;
      br_illegal_reg  <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      pc_sel_reg      <= mispredict;
      flush_reg       <= mispredict;
      br_illegal_reg  <= resolve & ~legal;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  assign pc_sel      = pc_sel_reg;
  assign flush       = flush_reg;
  assign br_illegal  = br_illegal_reg;
  assign redirect_pc = redirect_pc_reg;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (bht_update) stat_branches_reg    <= stat_branches_reg + 32'd1;
      if (mispredict) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed and randomized bench for branch_unit_bht against a behavioural model.
// Stats outputs are checked when BRANCH_STATS_EN is defined.
module tb_branch_unit_bht;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic [2:0]  ex_func3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        ex_pred_taken;
  logic        pc_sel;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        br_illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int          m_ctr [64];
  bit          m_pc_sel, m_flush, m_ill;
  logic [31:0] m_redir;
  longint      m_nbr, m_nmis;

  always #5 clk = ~clk;

  branch_unit_bht dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_func3      (ex_func3),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_pred_taken (ex_pred_taken),
    .pc_sel        (pc_sel),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
`ifdef BRANCH_STATS_EN
    .br_illegal       (br_illegal),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`else
    .br_illegal    (br_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit pred_of(input logic [31:0] pc);
    return m_ctr[idx_of(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_pc_sel = 0; m_flush = 0; m_ill = 0; m_redir = 0;
    m_nbr = 0; m_nmis = 0;
  endtask

  // Rules of the branch unit written directly as arithmetic on the model state.
  task automatic model_step();
    bit resolve, legal, taken, mis;
    int k;
    resolve = ex_valid && ex_branch && !m_flush;
    legal   = !(ex_func3 == 3'd2 || ex_func3 == 3'd3);
    case (ex_func3)
      3'd0:    taken = (ex_rs1 == ex_rs2);
      3'd1:    taken = (ex_rs1 != ex_rs2);
      3'd4:    taken = (int'(ex_rs1) <  int'(ex_rs2));
      3'd5:    taken = (int'(ex_rs1) >= int'(ex_rs2));
      3'd6:    taken = (longint'(ex_rs1) <  longint'(ex_rs2));
      3'd7:    taken = (longint'(ex_rs1) >= longint'(ex_rs2));
      default: taken = 0;
    endcase
    mis      = resolve && legal && (taken != ex_pred_taken);
    m_pc_sel = mis;
    m_flush  = mis;
    m_ill    = resolve && !legal;
    if (mis) m_redir = taken ? 32'((longint'(ex_pc) + longint'(ex_imm)) % (64'd1 << 32))
                             : 32'((longint'(ex_pc) + 4) % (64'd1 << 32));
    if (resolve && legal) begin
      k = idx_of(ex_pc);
      if (taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
      else       m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
      m_nbr++;
    end
    if (mis) m_nmis++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc_sel"},  {31'd0, pc_sel},     {31'd0, m_pc_sel});
    check({tag, ".flush"},   {31'd0, flush},      {31'd0, m_flush});
    check({tag, ".illegal"}, {31'd0, br_illegal}, {31'd0, m_ill});
    check({tag, ".redir"},   redirect_pc,         m_redir);
`ifdef BRANCH_STATS_EN
    check({tag, ".nbr"},  stat_branches,    32'(m_nbr));
    check({tag, ".nmis"}, stat_mispredicts, 32'(m_nmis));
`endif
  endtask

  // Inputs are set just after a posedge; this checks the prediction, clocks once, checks results.
  task automatic run_cycle(input string tag);
    #1;
    check({tag, ".pred"}, {31'd0, if_pred_taken}, {31'd0, pred_of(if_pc)});
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("%s: v=%0b br=%0b f3=%0d rs1=%h rs2=%h pc=%h imm=%h pred=%0b -> pc_sel=%0b flush=%0b ill=%0b redir=%h",
             tag, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
             pc_sel, flush, br_illegal, redirect_pc);
  endtask

  task automatic drive(input bit v, input bit b, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] bb, input logic [31:0] pc, input logic [31:0] imm,
                       input bit pred, input logic [31:0] ipc);
    ex_valid = v; ex_branch = b; ex_func3 = f3; ex_rs1 = a; ex_rs2 = bb;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; if_pc = ipc;
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, if_pc);
    run_cycle(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    check_outputs("rst");
    for (int i = 0; i < 4; i++) begin
      if_pc = $urandom;
      #1;
      check("rst.pred", {31'd0, if_pred_taken}, 32'd0);
    end

    // BEQ taken, predicted not-taken -> redirect to 0x120
    drive(1, 1, 3'd0, 5, 5, 32'h100, 32'h20, 0, 32'h100);
    run_cycle("beq");
    check("beq.pc_sel_c", {31'd0, pc_sel}, 32'd1);
    check("beq.flush_c",  {31'd0, flush},  32'd1);
    check("beq.redir_c",  redirect_pc,     32'h120);
    idle("beq_after");
    check("beq_after.pc_sel_c", {31'd0, pc_sel}, 32'd0);
    check("beq_after.redir_c",  redirect_pc,     32'h120);

    // signed vs unsigned less-than on the same operands
    drive(1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1, 32'h300);
    run_cycle("blt");
    check("blt.pc_sel_c", {31'd0, pc_sel}, 32'd0);
    drive(1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h300, 32'h40, 1, 32'h300);
    run_cycle("bltu");
    check("bltu.redir_c", redirect_pc, 32'h304);
    idle("bltu_after");

    // training: 3 taken then 2 not-taken on the same PC
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'd1, 1, 2, 32'h204, 32'h10, pred_of(32'h204), 32'h204);
      run_cycle("train_t");
      idle("train_gap");
    end
    if_pc = 32'h204; #1;
    check("sat.pred_c", {31'd0, if_pred_taken}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 3'd1, 7, 7, 32'h204, 32'h10, pred_of(32'h204), 32'h204);
      run_cycle("train_nt");
      idle("train_gap");
    end
    if_pc = 32'h204; #1;
    check("unsat.pred_c", {31'd0, if_pred_taken}, 32'd0);

    // reserved funct3: one-cycle illegal pulse, no redirect, no training
    drive(1, 1, 3'd2, 3, 3, 32'h204, 32'h10, 1, 32'h204);
    run_cycle("ill");
    check("ill.pulse_c",  {31'd0, br_illegal}, 32'd1);
    check("ill.pc_sel_c", {31'd0, pc_sel},     32'd0);
    idle("ill_after");
    check("ill_after.pulse_c", {31'd0, br_illegal}, 32'd0);
    if_pc = 32'h204; #1;
    check("ill.pred_c", {31'd0, if_pred_taken}, 32'd0);

    // PC wrap-around on the taken target
    drive(1, 1, 3'd7, 3, 3, 32'hFFFF_FFF0, 32'h20, 0, 32'h0);
    run_cycle("wrap");
    check("wrap.redir_c", redirect_pc, 32'h10);
    idle("wrap_after");

    // mispredict then a branch in the flush cycle, from a clean reset
    do_reset();
    check_outputs("rst2");
    drive(1, 1, 3'd0, 5, 5, 32'h100, 32'h20, 0, 32'h208);
    run_cycle("mis1");
    drive(1, 1, 3'd1, 1, 2, 32'h208, 32'h40, 0, 32'h208);
    run_cycle("mis2");
    check("mis2.pc_sel_c", {31'd0, pc_sel}, 32'd0);
    check("mis2.redir_c",  redirect_pc,     32'h120);
    if_pc = 32'h208; #1;
    check("mis2.pred_c", {31'd0, if_pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("mis2.nbr_c",  stat_branches,    32'd1);
    check("mis2.nmis_c", stat_mispredicts, 32'd1);
`endif

    // asynchronous reset mid-cycle while a redirect is pending
    drive(1, 1, 3'd0, 9, 9, 32'h400, 32'h80, 0, 32'h400);
    run_cycle("pend");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    check("async_rst.pred", {31'd0, if_pred_taken}, 32'd0);
    drive(1, 1, 3'd0, 9, 9, 32'h400, 32'h80, 0, 32'h400);
    @(posedge clk); #1;
    check_outputs("in_rst");
    @(negedge clk);
    drive(0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) pc = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            rnd_opnd(), rnd_opnd(), pc, rnd_opnd(),
            ($urandom_range(0, 1) == 1) ? pred_of(pc) : 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 1) ? pc : ({$urandom} & 32'h0000_03FC));
      run_cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
